// File: rtl/uart_tx_word_feeder.sv
// uart_tx_word_feeder
//   Queues WORD_W-bit words in a small FIFO and feeds them to a UART
//   transmitter one N-bit byte at a time, least-significant byte first,
//   using a tx_start / tx_done handshake.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   wr_en     write strobe; word accepted when full=0, otherwise dropped
//   wr_data   word to queue
//   full      FIFO holds 2**DEPTH_LOG2 words
//   empty     FIFO holds no words
//   busy      a word is being sent or words are queued
//   tx_start  one-cycle frame request to the transmitter
//   tx_data   byte for the transmitter, held from tx_start until tx_done
//   tx_done   one-cycle frame-complete pulse from the transmitter
//
// Build option
//   UART_TX_FEEDER_OVF_EN adds a sticky overflow flag (output overflow)
//   that records dropped writes, cleared by input ovf_clr.
//
// FSM states
//   state  | meaning
//   IDLE   | no word in flight; pops the FIFO head when one is available
//   SEND   | tx_start high for this single cycle
//   WAIT   | frame in progress; tx_done selects next byte or IDLE
module uart_tx_word_feeder #(
   parameter int WORD_W     = 32,
   parameter int N          = 8,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] wr_data,
   output logic              full,
   output logic              empty,
   output logic              busy,
   output logic              tx_start,
   output logic [N-1:0]      tx_data,
   input  logic              tx_done
`ifdef UART_TX_FEEDER_OVF_EN
   ,
   output logic              overflow,
   input  logic              ovf_clr
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int BYTES = WORD_W / N;
   localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES - 1);
   localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   OCC_ONE   = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0]   OCC_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

   state_t                  state_q, state_d;
   logic [WORD_W-1:0]       mem_q [DEPTH];
   logic [WORD_W-1:0]       mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic [WORD_W-1:0]       shift_q, shift_d;
   logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
   logic                    push;
   logic                    pop;

   assign full  = (count_q == OCC_FULL);
   assign empty = (count_q == '0);

   // A write against a full FIFO is dropped even when the FSM pops in the
   // same cycle, so push only looks at the registered occupancy.
   assign push = wr_en & ~full;
   assign pop  = (state_q == S_IDLE) & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + OCC_ONE;
         2'b01:   count_d = count_q - OCC_ONE;
         default: count_d = count_q;
      endcase
   end

   // next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (!empty) state_d = S_SEND;
         S_SEND: state_d = S_WAIT;
         S_WAIT: if (tx_done) state_d = (byte_cnt_q == LAST_BYTE) ? S_IDLE : S_SEND;
         default: state_d = S_IDLE;
      endcase
   end

   // word shift register and byte counter; the current byte always sits in
   // the low N bits so tx_data needs no mux
   always_comb begin
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt_q;
      if (pop) begin
         shift_d    = mem_q[rd_ptr_q];
         byte_cnt_d = '0;
      end else if ((state_q == S_WAIT) && tx_done && (byte_cnt_q != LAST_BYTE)) begin
         shift_d    = shift_q >> N;
         byte_cnt_d = byte_cnt_q + CNT_ONE;
      end
   end

   // outputs
   always_comb begin
      tx_start = (state_q == S_SEND);
      tx_data  = shift_q[N-1:0];
      busy     = (state_q != S_IDLE) | ~empty;
   end

`ifdef UART_TX_FEEDER_OVF_EN
   logic overflow_q, overflow_d;

   always_comb begin
      overflow_d = overflow_q;
      if (ovf_clr) begin
         overflow_d = 1'b0;
      end else if (wr_en && full) begin
         overflow_d = 1'b1;
      end
   end

   assign overflow = overflow_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         shift_q    <= '0;
         byte_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_word_feeder.sv
// Testbench for uart_tx_word_feeder (default parameters: 32-bit words,
// 8-bit bytes, 4-word FIFO). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_uart_tx_word_feeder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic        full, empty, busy, tx_start;
   logic [7:0]  tx_data;
   logic        tx_done = 1'b0;
`ifdef UART_TX_FEEDER_OVF_EN
   logic        overflow;
   logic        ovf_clr = 1'b0;
`endif

   always #5 clk = ~clk;

   uart_tx_word_feeder dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .busy     (busy),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_done  (tx_done)
`ifdef UART_TX_FEEDER_OVF_EN
      ,
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transmitter stand-in for directed tests ----------------
   int          cyc;
   int          waitc;
   int          done_cyc;
   int          tx_delay;
   bit          hold_done;
   logic [7:0]  held;
   logic [7:0]  got[$];
   logic [7:0]  exp_q[$];
   int          gaps[$];

   task automatic clear_tx();
      got.delete();
      exp_q.delete();
      gaps.delete();
      waitc     = -1;
      done_cyc  = -1000;
      hold_done = 1'b0;
      cyc       = 0;
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
   endtask

   // one clock: sample outputs, answer frames, then drive the write port
   task automatic cycle(input logic we, input logic [31:0] wd);
      @(negedge clk);
      cyc++;
      if (tx_start) begin
         got.push_back(tx_data);
         gaps.push_back(cyc - done_cyc);
         held  = tx_data;
         waitc = tx_delay;
      end else if (waitc >= 0) begin
         chk("tx_data_stable", 32'(tx_data), 32'(held));
      end
      if (!hold_done && waitc == 0) begin
         tx_done  = 1'b1;
         waitc    = -1;
         done_cyc = cyc;
      end else begin
         tx_done = 1'b0;
         if (!hold_done && waitc > 0) waitc--;
      end
      wr_en   = we;
      wr_data = wd;
   endtask

   task automatic run_until(input int nbytes, input int budget);
      int n = 0;
      while ((got.size() < nbytes || waitc >= 0) && n < budget) begin
         cycle(1'b0, 32'h0);
         n++;
      end
      chk("frames_within_budget", 32'(got.size()), 32'(nbytes));
   endtask

   task automatic chk_bytes(input string name);
      chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         chk(name, 32'(got[i]), 32'(exp_q[i]));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b0;
      wr_en   = 1'b0;
      tx_done = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      clear_tx();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       we;
      logic [31:0] wd;
      logic       done;
      logic       e_empty;
      logic       e_full;
      logic       e_busy;
      logic       e_start;
      logic       chk_data;
      logic [7:0] e_data;
   } vec_t;

   vec_t vt[14];

   function automatic vec_t mk(input logic we, input logic [31:0] wd, input logic done,
                               input logic e_empty, input logic e_full, input logic e_busy,
                               input logic e_start, input logic chk_data, input logic [7:0] e_data);
      vec_t v;
      v.we = we; v.wd = wd; v.done = done;
      v.e_empty = e_empty; v.e_full = e_full; v.e_busy = e_busy;
      v.e_start = e_start; v.chk_data = chk_data; v.e_data = e_data;
      return v;
   endfunction

   // ---------------- random-test reference model ----------------
   logic [31:0] m_fifo[$];
   logic [7:0]  m_bytes[$];
   int          m_phase;   // 0 no word, 1 start cycle, 2 awaiting done

   task automatic model_edge(input logic we, input logic [31:0] wd, input logic done);
      logic [31:0] w;
      bit accept;
      accept = we && (m_fifo.size() < 4);
      if (m_phase == 0) begin
         if (m_fifo.size() > 0) begin
            w = m_fifo.pop_front();
            m_bytes.delete();
            for (int b = 0; b < 4; b++) m_bytes.push_back(w[8*b +: 8]);
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else if (done) begin
         void'(m_bytes.pop_front());
         m_phase = (m_bytes.size() == 0) ? 0 : 1;
      end
      if (accept) m_fifo.push_back(wd);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [31:0] w4[6];
      logic we, dn;
      logic [31:0] wd;

      vt[0]  = mk(1'b1, 32'hA1B2C3D4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      vt[1]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hD4); // stray done in IDLE
      vt[2]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hD4); // stray done in SEND
      vt[3]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3);
      vt[4]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC3);
      vt[5]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB2);
      vt[6]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB2);
      vt[7]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1);
      vt[8]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1);
      vt[9]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      vt[10] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // stray done in IDLE
      vt[11] = mk(1'b1, 32'h55667788, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      vt[12] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h88);
      vt[13] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h88);

      tx_delay = 1;
      clear_tx();
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // ---- reset behaviour, asserted while a word is in flight ----
      @(negedge clk); wr_en = 1'b1; wr_data = 32'hCAFEF00D;
      @(negedge clk); wr_en = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0; wr_en = 1'b1; wr_data = 32'hDEADBEEF;
      #1;
      chk("rst_async_empty", 32'(empty), 32'd1);
      chk("rst_async_start", 32'(tx_start), 32'd0);
      chk("rst_async_data",  32'(tx_data), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_empty", 32'(empty), 32'd1);
         chk("rst_full",  32'(full), 32'd0);
         chk("rst_busy",  32'(busy), 32'd0);
         chk("rst_start", 32'(tx_start), 32'd0);
         chk("rst_data",  32'(tx_data), 32'd0);
`ifdef UART_TX_FEEDER_OVF_EN
         chk("rst_overflow", 32'(overflow), 32'd0);
`endif
      end
      reset = 1'b1; wr_en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_empty", 32'(empty), 32'd1);
         chk("post_rst_busy",  32'(busy), 32'd0);
         chk("post_rst_start", 32'(tx_start), 32'd0);
      end

      // ---- table: single word, fast transmitter, stray tx_done ----
      for (int i = 0; i < 14; i++) begin
         wr_en = vt[i].we; wr_data = vt[i].wd; tx_done = vt[i].done;
         @(negedge clk);
         chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].e_empty));
         chk($sformatf("vec%0d_full", i),  32'(full), 32'(vt[i].e_full));
         chk($sformatf("vec%0d_busy", i),  32'(busy), 32'(vt[i].e_busy));
         chk($sformatf("vec%0d_start", i), 32'(tx_start), 32'(vt[i].e_start));
         if (vt[i].chk_data) chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vt[i].e_data));
      end
      wr_en = 1'b0; tx_done = 1'b0;

      // ---- single word, 20-cycle frames ----
      do_reset();
      tx_delay = 20;
      push_word(32'hA1B2C3D4);
      cycle(1'b1, 32'hA1B2C3D4);
      run_until(4, 300);
      chk("single_busy_at_last_done", 32'(busy), 32'd1);
      cycle(1'b0, 32'h0);
      cycle(1'b0, 32'h0);
      chk("single_busy_fall", 32'(busy), 32'd0);
      repeat (6) cycle(1'b0, 32'h0);
      chk_bytes("single_bytes");

      // ---- back-to-back words ----
      do_reset();
      tx_delay = 3;
      push_word(32'h11223344);
      push_word(32'h55667788);
      cycle(1'b1, 32'h11223344);
      cycle(1'b1, 32'h55667788);
      run_until(8, 300);
      repeat (4) cycle(1'b0, 32'h0);
      chk_bytes("b2b_bytes");
      if (gaps.size() >= 5) begin
         chk("b2b_gap_inter_byte", 32'(gaps[1]), 32'd1);
         chk("b2b_gap_word", 32'(gaps[4]), 32'd2);
      end else begin
         chk("b2b_gap_available", 32'(gaps.size()), 32'd5);
      end
      chk("b2b_idle_after", 32'(busy), 32'd0);

      // ---- full / drop ----
      do_reset();
      tx_delay  = 2;
      hold_done = 1'b1;
      for (int i = 0; i < 6; i++) begin
         w4[i] = 32'h10203040 + 32'(i) * 32'h01010101;
         if (i < 5) push_word(w4[i]);
      end
      for (int i = 0; i < 6; i++) cycle(1'b1, w4[i]);
      cycle(1'b0, 32'h0);
      chk("full_after_fill", 32'(full), 32'd1);
      chk("full_not_empty", 32'(empty), 32'd0);
`ifdef UART_TX_FEEDER_OVF_EN
      chk("ovf_set", 32'(overflow), 32'd1);
      cycle(1'b0, 32'h0);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      cycle(1'b0, 32'h0);
      ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);
      wr_en = 1'b1; wr_data = 32'hFFFF0000; ovf_clr = 1'b1;
      cycle(1'b0, 32'h0);
      ovf_clr = 1'b0;
      chk("ovf_clr_priority", 32'(overflow), 32'd0);
      chk("full_still", 32'(full), 32'd1);
`endif
      hold_done = 1'b0;
      run_until(20, 800);
      repeat (4) cycle(1'b0, 32'h0);
      chk_bytes("full_bytes");
      chk("full_drained_empty", 32'(empty), 32'd1);
      chk("full_drained_busy", 32'(busy), 32'd0);

      // ---- reset mid-word ----
      do_reset();
      tx_delay = 3;
      cycle(1'b1, 32'hAABBCCDD);
      cycle(1'b1, 32'h01234567);
      cycle(1'b1, 32'h89ABCDEF);
      run_until(2, 200);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_start", 32'(tx_start), 32'd0);
      chk("midrst_empty", 32'(empty), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      waitc = -1;
      repeat (3) cycle(1'b0, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (10) cycle(1'b0, 32'h0);
      chk("midrst_no_more_frames", 32'(got.size()), 32'd2);
      chk("midrst_after_empty", 32'(empty), 32'd1);
      chk("midrst_after_busy", 32'(busy), 32'd0);

      // ---- randomized against the queue model ----
      do_reset();
      m_fifo.delete();
      m_bytes.delete();
      m_phase = 0;
      base = n_fail;
      for (int i = 0; i < 3000; i++) begin
         we = ($urandom_range(0, 2) == 0);
         wd = $urandom;
         dn = ($urandom_range(0, 3) == 0);
         wr_en = we; wr_data = wd; tx_done = dn;
         model_edge(we, wd, dn);
         @(negedge clk);
         chk("rnd_empty", 32'(empty), 32'(m_fifo.size() == 0));
         chk("rnd_full",  32'(full), 32'(m_fifo.size() == 4));
         chk("rnd_busy",  32'(busy), 32'((m_phase != 0) || (m_fifo.size() != 0)));
         chk("rnd_start", 32'(tx_start), 32'(m_phase == 1));
         if (m_phase != 0) chk("rnd_data", 32'(tx_data), 32'(m_bytes[0]));
         if (n_fail - base > 20) break;
      end
      wr_en = 1'b0; tx_done = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
